mul_issue_arbiter: RTL

- Shares one pipelined Booth multiplier (partial-product generator, compression, final add; valid/ready at every stage; results return in order) among NREQ requesters.
- Round-robin arbitration of operand requests into a registered issue stage.
- In-order ID FIFO tracks in-flight operations; each returning 64-bit product is routed to the requester that issued it.
- In-flight count is capped at DEPTH so pipeline backpressure can never overflow the ID FIFO.

---
 rtl/mul_issue_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: round-robin issue of operand requests from NREQ
// requesters into one shared in-order pipelined multiplier, with an ID FIFO
// that steers each returning product back to the requester that issued it.
// Issue is capped at DEPTH operations in flight so the ID FIFO never overflows.
module mul_issue_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // requester operand side
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*32-1:0]         req_a_i,
    input  logic [NREQ*32-1:0]         req_b_i,
    // multiplier operand side
    output logic                       mul_valid_o,
    input  logic                       mul_ready_i,
    output logic [31:0]                mul_a_o,
    output logic [31:0]                mul_b_o,
    // multiplier product side
    input  logic                       mul_valid_i,
    output logic                       mul_ready_o,
    input  logic [63:0]                mul_p_i,
    // requester product side
    output logic [NREQ-1:0]            rsp_valid_o,
    input  logic [NREQ-1:0]            rsp_ready_i,
    output logic [63:0]                rsp_p_o,
    // status
    output logic [$clog2(DEPTH):0]     inflight_o,
    output logic                       err_o
);

    localparam int AW = $clog2(DEPTH);   // ID FIFO address width
    localparam int CW = AW + 1;          // pointer width, extra wrap bit

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW:0]   scan_idx;
    logic           win_found;
    logic [31:0]    win_a;
    logic [31:0]    win_b;
    logic           load;

    logic [IDW-1:0] id_mem [DEPTH];
    logic [CW-1:0]  wr_ptr;
    logic [CW-1:0]  rd_ptr;
    logic           fifo_empty;
    logic [IDW-1:0] head_id;
    logic           pop;

    // Round-robin scan: first valid requester starting at rr_ptr, with wrap.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!win_found && req_valid_i[scan_idx[IDW-1:0]]) begin
                winner    = scan_idx[IDW-1:0];
                win_found = 1'b1;
            end
        end
    end

    // Select the winning requester's operands from the packed buses.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IDW'(k)) begin
                win_a = req_a_i[32*k +: 32];
                win_b = req_b_i[32*k +: 32];
            end
        end
    end

    // A new operand pair loads when the issue register is free or draining,
    // the in-flight cap is not reached, and someone is asking. A same-cycle
    // pop deliberately does not relax the cap.
    assign load = (!mul_valid_o || mul_ready_i)
                  && (inflight_o < CW'(DEPTH))
                  && (|req_valid_i);

    // Grant is one-hot on the winner, only in a load cycle.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready_o[k] = load && (winner == IDW'(k));
        end
    end

    // Issue register: capture the winner on load, retire when the multiplier takes it.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
        end else if (load) begin
            mul_valid_o <= 1'b1;
            mul_a_o     <= win_a;
            mul_b_o     <= win_b;
        end else if (mul_ready_i) begin
            mul_valid_o <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the requester that was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (load) begin
            rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
        end
    end

    // ID FIFO storage: record which requester owns each issued operation.
    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (load) begin
            id_mem[wr_ptr[AW-1:0]] <= winner;
        end
    end

    // ID FIFO pointers; push on issue, pop when a product is handed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (load) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign inflight_o = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head_id    = id_mem[rd_ptr[AW-1:0]];
    assign rsp_p_o    = mul_p_i;

    // Return steering: the FIFO head owns the product currently at the
    // multiplier output; a product with no owner is swallowed.
    always_comb begin
        rsp_valid_o = '0;
        mul_ready_o = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[head_id] = mul_valid_i;
            mul_ready_o          = rsp_ready_i[head_id];
        end else begin
            mul_ready_o = mul_valid_i;
        end
    end

    assign pop = mul_valid_i && mul_ready_o && !fifo_empty;

    // Sticky error: a product arrived that no issued operation accounts for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (mul_valid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule
